// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding,
// default width and the signed-overflow rule.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

  // Overflow when both addends share a sign and the result sign differs.
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// Combinational 1-bit full adder; the only arithmetic in the serial adder.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, with in/out handshakes.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] shift_a, shift_b, res;
  logic [WIDTH-1:0] b_eff;
  logic [CNT_W-1:0] cnt;
  logic             carry, a_msb, b_msb, cin_eff;
  logic             accept, last_bit, s_bit, co_bit;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b == a + ~b + 1
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : c_in;
`else
  assign b_eff   = b;
  assign cin_eff = c_in;
`endif

  assign accept   = in_valid & in_ready;
  assign last_bit = (state == S_RUN) && (cnt == CNT_LAST);

  fa_bit_cell u_cell (
    .a  (shift_a[0]),
    .b  (shift_b[0]),
    .cin(carry),
    .s  (s_bit),
    .co (co_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Result registers only change on the final RUN cycle; they hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_a <= '0;
      shift_b <= '0;
      res     <= '0;
      carry   <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      shift_a <= a;
      shift_b <= b_eff;
      carry   <= cin_eff;
      a_msb   <= a[WIDTH-1];
      b_msb   <= b_eff[WIDTH-1];
      cnt     <= '0;
    end else if (state == S_RUN) begin
      shift_a <= shift_a >> 1;
      shift_b <= shift_b >> 1;
      res     <= {s_bit, res[WIDTH-1:1]};
      carry   <= co_bit;
      if (!last_bit) cnt <= cnt + CNT_W'(1);
      if (last_bit) begin
        sum   <= {s_bit, res[WIDTH-1:1]};
        c_out <= co_bit;
        ovf   <= calc_ovf(a_msb, b_msb, s_bit);
      end
    end
  end

endmodule
